// File: rtl/meas_sched.sv
// meas_sched -- measurement scheduler for a shared period/frequency datapath.
//
// Time-shares one frequency-classification datapath among NCH input signals.
// For each enabled channel it:
//   - switches the input mux;
//   - holds the datapath in reset for SETTLE cycles;
//   - runs one full 2^WIN_BITS measurement window;
//   - captures the 8-bit frequency code.
// The code is stored per channel and offered on a valid/ready report stream.
//
// Optional feature macro: MEAS_CONFIRM_EN
//   Defined:   a per-channel shadow of the previous raw code is kept. The stored
//              result only updates when two consecutive captures agree and are
//              non-zero.
//   Undefined: every capture is stored directly, and no shadow storage exists.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   start        one-cycle pulse, begins a scan pass from IDLE
//   continuous   1 = wrap around and keep scanning (sampled in NEXT)
//   ch_enable    per-channel enable (sampled in IDLE and NEXT)
//   ch_sel       input mux select to the datapath
//   meas_rst     active-high datapath reset
//   meas_code    datapath frequency code (0 = no bin)
//   result_code  latest accepted code per channel, channel k at [8k+7:8k]
//   result_valid channel has at least one accepted code
//   out_valid    report stream valid
//   out_ready    report stream ready
//   out_ch       report channel
//   out_code     report code (always the raw captured code)
//   busy         scheduler not idle
module meas_sched #(
  parameter int NCH      = 4,
  parameter int WIN_BITS = 20,
  parameter int SETTLE   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               continuous,
  input  logic [NCH-1:0]     ch_enable,
  output logic [2:0]         ch_sel,
  output logic               meas_rst,
  input  logic [7:0]         meas_code,
  output logic [8*NCH-1:0]   result_code,
  output logic [NCH-1:0]     result_valid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_ch,
  output logic [7:0]         out_code,
  output logic               busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN,
    ST_CAPTURE,
    ST_REPORT,
    ST_NEXT
  } state_t;

  // The settle counter runs 0..SETTLE-1.
  // The run counter runs 0..2^WIN_BITS, so the window is 2^WIN_BITS+1 cycles.
  // The extra cycle covers the datapath's register-after-window update.
  localparam int                SCW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCW-1:0]    SETTLE_LAST = SCW'(SETTLE - 1);
  localparam logic [SCW-1:0]    SETTLE_ONE  = SCW'(1);
  localparam logic [WIN_BITS:0] RUN_LAST    = {1'b1, {WIN_BITS{1'b0}}};
  localparam logic [WIN_BITS:0] RUN_ONE     = {{WIN_BITS{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [2:0]          ch_sel_q, ch_sel_d;
  logic                meas_rst_q, meas_rst_d;
  logic                busy_q, busy_d;
  logic [SCW-1:0]      settle_cnt_q, settle_cnt_d;
  logic [WIN_BITS:0]   run_cnt_q, run_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [2:0]          out_ch_q, out_ch_d;
  logic [7:0]          out_code_q, out_code_d;
  logic [8*NCH-1:0]    result_code_q, result_code_d;
  logic [NCH-1:0]      result_valid_q, result_valid_d;
`ifdef MEAS_CONFIRM_EN
  logic [7:0]          shadow_q [NCH];
  logic [7:0]          shadow_d [NCH];
`endif

  logic [3:0]          lowest_hit;
  logic [3:0]          above_hit;

  // Lowest enabled channel. Result format is {found, index}.
  function automatic logic [3:0] find_lowest(input logic [NCH-1:0] en);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (en[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Lowest enabled channel strictly above cur, with no wrap-around.
  function automatic logic [3:0] find_above(input logic [NCH-1:0] en,
                                            input logic [2:0]     cur);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (en[i] && (3'(i) > cur)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign lowest_hit = find_lowest(ch_enable);
  assign above_hit  = find_above(ch_enable, ch_sel_q);

  // Next-state logic for the scheduler.
  // The registered outputs meas_rst and busy are derived from the next state.
  // This makes them change on the same edge as the state, with no extra cycle
  // of lag.
  always_comb begin
    state_d        = state_q;
    ch_sel_d       = ch_sel_q;
    settle_cnt_d   = settle_cnt_q;
    run_cnt_d      = run_cnt_q;
    out_valid_d    = out_valid_q;
    out_ch_d       = out_ch_q;
    out_code_d     = out_code_q;
    result_code_d  = result_code_q;
    result_valid_d = result_valid_q;
`ifdef MEAS_CONFIRM_EN
    shadow_d       = shadow_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start && lowest_hit[3]) begin
          ch_sel_d     = lowest_hit[2:0];
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          run_cnt_d = '0;
          state_d   = ST_RUN;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_ONE;
        end
      end

      ST_RUN: begin
        run_cnt_d = run_cnt_q + RUN_ONE;
        if (run_cnt_q == RUN_LAST) state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        out_code_d  = meas_code;
        out_ch_d    = ch_sel_q;
        out_valid_d = 1'b1;
        for (int k = 0; k < NCH; k++) begin
          if (ch_sel_q == 3'(k)) begin
`ifdef MEAS_CONFIRM_EN
            // Accept only a non-zero code that repeats the previous capture.
            if ((meas_code != 8'd0) && (meas_code == shadow_q[k])) begin
              result_code_d[8*k +: 8] = meas_code;
              result_valid_d[k]       = 1'b1;
            end
            shadow_d[k] = meas_code;
`else
            result_code_d[8*k +: 8] = meas_code;
            if (meas_code != 8'd0) result_valid_d[k] = 1'b1;
`endif
          end
        end
        state_d = ST_REPORT;
      end

      ST_REPORT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_NEXT;
        end
      end

      ST_NEXT: begin
        if (ch_enable == '0) begin
          state_d = ST_IDLE;
        end else if (above_hit[3]) begin
          ch_sel_d     = above_hit[2:0];
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end else if (continuous) begin
          ch_sel_d     = lowest_hit[2:0];
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    meas_rst_d = (state_d == ST_IDLE) || (state_d == ST_SETTLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // All scheduler state is held here.
  // A synchronous reset discards any measurement in flight and puts the
  // datapath back into reset on the next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ch_sel_q       <= 3'd0;
      meas_rst_q     <= 1'b1;
      busy_q         <= 1'b0;
      settle_cnt_q   <= '0;
      run_cnt_q      <= '0;
      out_valid_q    <= 1'b0;
      out_ch_q       <= 3'd0;
      out_code_q     <= 8'd0;
      result_code_q  <= '0;
      result_valid_q <= '0;
`ifdef MEAS_CONFIRM_EN
      for (int k = 0; k < NCH; k++) shadow_q[k] <= 8'd0;
`endif
    end else begin
      state_q        <= state_d;
      ch_sel_q       <= ch_sel_d;
      meas_rst_q     <= meas_rst_d;
      busy_q         <= busy_d;
      settle_cnt_q   <= settle_cnt_d;
      run_cnt_q      <= run_cnt_d;
      out_valid_q    <= out_valid_d;
      out_ch_q       <= out_ch_d;
      out_code_q     <= out_code_d;
      result_code_q  <= result_code_d;
      result_valid_q <= result_valid_d;
`ifdef MEAS_CONFIRM_EN
      for (int k = 0; k < NCH; k++) shadow_q[k] <= shadow_d[k];
`endif
    end
  end

  assign ch_sel       = ch_sel_q;
  assign meas_rst     = meas_rst_q;
  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign out_ch       = out_ch_q;
  assign out_code     = out_code_q;
  assign result_code  = result_code_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_meas_sched.sv
// tb_meas_sched -- directed, table-driven bench for meas_sched.
// Configuration: NCH=4, WIN_BITS=6, SETTLE=4.
// The stub datapath returns 3+ch_sel unless an override code is forced.
module tb_meas_sched;

  localparam int NCH = 4;
  localparam int WB  = 6;
  localparam int ST  = 4;
  localparam int FIRST_LAT = ST + (1 << WB) + 2;
  localparam int NEXT_LAT  = FIRST_LAT + 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              continuous;
  logic [NCH-1:0]    ch_enable;
  logic [2:0]        ch_sel;
  logic              meas_rst;
  logic [7:0]        meas_code;
  logic [8*NCH-1:0]  result_code;
  logic [NCH-1:0]    result_valid;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_ch;
  logic [7:0]        out_code;
  logic              busy;

  logic              use_ovr;
  logic [7:0]        ovr_code;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int vcnt     = 0;

  meas_sched #(.NCH(NCH), .WIN_BITS(WB), .SETTLE(ST)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .continuous   (continuous),
    .ch_enable    (ch_enable),
    .ch_sel       (ch_sel),
    .meas_rst     (meas_rst),
    .meas_code    (meas_code),
    .result_code  (result_code),
    .result_valid (result_valid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ch       (out_ch),
    .out_code     (out_code),
    .busy         (busy)
  );

  // Stub datapath.
  assign meas_code = use_ovr ? ovr_code : (8'd3 + {5'd0, ch_sel});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (out_valid === 1'b1) vcnt <= vcnt + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct packed {
    logic [3:0]      en;
    logic [2:0]      n;
    logic [3:0][2:0] chs;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] en, input logic cont,
                               input logic rdy);
    ch_enable  = en;
    continuous = cont;
    out_ready  = rdy;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ch_sel"},       32'(ch_sel),       32'd0);
    checkOutput({tag, "_meas_rst"},     32'(meas_rst),     32'd1);
    checkOutput({tag, "_busy"},         32'(busy),         32'd0);
    checkOutput({tag, "_out_valid"},    32'(out_valid),    32'd0);
    checkOutput({tag, "_out_ch"},       32'(out_ch),       32'd0);
    checkOutput({tag, "_out_code"},     32'(out_code),     32'd0);
    checkOutput({tag, "_result_code"},  32'(result_code),  32'd0);
    checkOutput({tag, "_result_valid"}, 32'(result_valid), 32'd0);
  endtask

  // Pulse start for one cycle. Returns the cycle number at which busy is
  // first observable, which is the first SETTLE cycle.
  task automatic pulseStart(output int t0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic waitReport(input int bound, output int t, output logic ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic waitIdle(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int t0, t, prev, v0, bad;
    logic ok;
    logic [3:0] exp_rv;
    logic [8*NCH-1:0] exp_rc;

    rst_n      = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    ch_enable  = '0;
    out_ready  = 1'b1;
    use_ovr    = 1'b0;
    ovr_code   = 8'd0;

    vecs[0] = '{en: 4'b1011, n: 3'd3, chs: {3'd0, 3'd3, 3'd1, 3'd0}};
    vecs[1] = '{en: 4'b0100, n: 3'd1, chs: {3'd0, 3'd0, 3'd0, 3'd2}};
    vecs[2] = '{en: 4'b1111, n: 3'd4, chs: {3'd3, 3'd2, 3'd1, 3'd0}};
    vecs[3] = '{en: 4'b1000, n: 3'd1, chs: {3'd0, 3'd0, 3'd0, 3'd3}};
    vecs[4] = '{en: 4'b0000, n: 3'd0, chs: {3'd0, 3'd0, 3'd0, 3'd0}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    rst_n = 1'b1;

    // Single-pass table.
    for (int r = 0; r < 5; r++) begin
      doReset();
      applyStimulus(vecs[r].en, 1'b0, 1'b1);
      v0 = vcnt;
      pulseStart(t0);
      checkOutput("busy_after_start", 32'(busy), 32'(vecs[r].n != 3'd0));
      prev = t0;
      for (int k = 0; k < int'(vecs[r].n); k++) begin
        waitReport(200, t, ok);
        checkOutput("report_seen", 32'(ok), 32'd1);
        if (!ok) break;
        checkOutput("out_ch", 32'(out_ch), 32'(vecs[r].chs[k]));
        checkOutput("out_code", 32'(out_code), 32'(3 + int'(vecs[r].chs[k])));
        checkOutput("latency", 32'(t - prev), (k == 0) ? 32'(FIRST_LAT) : 32'(NEXT_LAT));
        prev = t;
      end
      waitIdle(50, ok);
      checkOutput("back_to_idle", 32'(ok), 32'd1);
      repeat (20) @(negedge clk);
      checkOutput("report_count", 32'(vcnt - v0), 32'(vecs[r].n));
      checkOutput("busy_final", 32'(busy), 32'd0);
      exp_rv = '0;
      exp_rc = '0;
`ifndef MEAS_CONFIRM_EN
      exp_rv = vecs[r].en;
      for (int c = 0; c < NCH; c++)
        if (vecs[r].en[c]) exp_rc[8*c +: 8] = 8'(3 + c);
`endif
      checkOutput("result_valid", 32'(result_valid), 32'(exp_rv));
      checkOutput("result_code", 32'(result_code), 32'(exp_rc));
    end

    // Backpressure: hold out_ready low at the first report.
    doReset();
    applyStimulus(4'b1011, 1'b0, 1'b0);
    pulseStart(t0);
    waitReport(200, t, ok);
    checkOutput("bp_report_seen", 32'(ok), 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_code !== 8'd3 ||
          ch_sel !== 3'd0 || meas_rst !== 1'b0) bad++;
    end
    checkOutput("bp_hold", 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_valid_drop", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("bp_next_ch", 32'(ch_sel), 32'd1);
    checkOutput("bp_next_rst", 32'(meas_rst), 32'd1);
    waitIdle(400, ok);
    checkOutput("bp_idle", 32'(ok), 32'd1);

    // Continuous scan with an enable change during the ch0 window.
    doReset();
    applyStimulus(4'b0011, 1'b1, 1'b1);
    pulseStart(t0);
    repeat (20) @(negedge clk);
    ch_enable = 4'b1000;
    waitReport(200, t, ok);
    checkOutput("cont_r0_ch", 32'(out_ch), 32'd0);
    checkOutput("cont_r0_code", 32'(out_code), 32'd3);
    prev = t;
    for (int k = 0; k < 2; k++) begin
      waitReport(200, t, ok);
      checkOutput("cont_seen", 32'(ok), 32'd1);
      checkOutput("cont_ch", 32'(out_ch), 32'd3);
      checkOutput("cont_code", 32'(out_code), 32'd6);
      checkOutput("cont_latency", 32'(t - prev), 32'(NEXT_LAT));
      prev = t;
    end
    continuous = 1'b0;
    waitIdle(10, ok);
    checkOutput("cont_stop", 32'(ok), 32'd1);

    // Reset mid-RUN, with an extra start pulse that must be ignored.
    doReset();
    applyStimulus(4'b0010, 1'b0, 1'b1);
    v0 = vcnt;
    pulseStart(t0);
    checkOutput("rr_ch_sel", 32'(ch_sel), 32'd1);
    repeat (20) @(negedge clk);
    ch_enable = 4'b0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("rr_start_ignored_ch", 32'(ch_sel), 32'd1);
    checkOutput("rr_start_ignored_rst", 32'(meas_rst), 32'd0);
    while (cyc < t0 + ST + 30) @(negedge clk);
    checkOutput("rr_in_run", 32'(meas_rst), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkReset("rr");
    repeat (100) @(negedge clk);
    checkOutput("rr_no_report", 32'(vcnt - v0), 32'd0);
    checkOutput("rr_busy", 32'(busy), 32'd0);

`ifdef MEAS_CONFIRM_EN
    // Confirmation: codes 5, 7, 7 on ch0.
    doReset();
    use_ovr  = 1'b1;
    ovr_code = 8'd5;
    applyStimulus(4'b0001, 1'b1, 1'b1);
    pulseStart(t0);
    waitReport(200, t, ok);
    checkOutput("cf_r1_code", 32'(out_code), 32'd5);
    checkOutput("cf_r1_result", 32'(result_code[7:0]), 32'd0);
    ovr_code = 8'd7;
    waitReport(200, t, ok);
    checkOutput("cf_r2_code", 32'(out_code), 32'd7);
    checkOutput("cf_r2_result", 32'(result_code[7:0]), 32'd0);
    checkOutput("cf_r2_valid", 32'(result_valid), 32'd0);
    waitReport(200, t, ok);
    continuous = 1'b0;
    checkOutput("cf_r3_code", 32'(out_code), 32'd7);
    checkOutput("cf_r3_result", 32'(result_code[7:0]), 32'd7);
    checkOutput("cf_r3_valid", 32'(result_valid), 32'd1);
    waitIdle(10, ok);
    checkOutput("cf_idle", 32'(ok), 32'd1);
    use_ovr = 1'b0;
`else
    // Zero code: the raw code is stored, but a valid flag already set stays set.
    doReset();
    use_ovr  = 1'b1;
    ovr_code = 8'd0;
    applyStimulus(4'b0001, 1'b0, 1'b1);
    pulseStart(t0);
    waitReport(200, t, ok);
    checkOutput("z_code", 32'(out_code), 32'd0);
    waitIdle(10, ok);
    checkOutput("z_valid", 32'(result_valid), 32'd0);
    ovr_code = 8'd9;
    pulseStart(t0);
    waitReport(200, t, ok);
    waitIdle(10, ok);
    checkOutput("z_nine_code", 32'(result_code), 32'd9);
    checkOutput("z_nine_valid", 32'(result_valid), 32'd1);
    ovr_code = 8'd0;
    pulseStart(t0);
    waitReport(200, t, ok);
    waitIdle(10, ok);
    checkOutput("z_zero_code", 32'(result_code), 32'd0);
    checkOutput("z_sticky_valid", 32'(result_valid), 32'd1);
    use_ovr = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
